// File: rtl/dm_pkg.sv
// Debug-module shared types: DMI request/response bundles and DTM codes.
// Also maps AXI-Lite response codes onto DTM response codes.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'd0,
        DTM_READ  = 2'd1,
        DTM_WRITE = 2'd2
    } dtm_op_e;

    localparam logic [1:0] DTM_SUCCESS = 2'd0;
    localparam logic [1:0] DTM_ERR     = 2'd2;
    localparam logic [1:0] DTM_BUSY    = 2'd3;

    typedef struct packed {
        logic [16:0] addr;
        logic [1:0]  op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    // SLVERR/DECERR both have bit 1 set; OKAY/EXOKAY do not.
    function automatic logic [1:0] axi_to_dtm(input logic [1:0] axi_resp);
        return axi_resp[1] ? DTM_ERR : DTM_SUCCESS;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bundle with initiator and target views.
// Data width is a parameter; strobes follow it.
interface AXI_LITE #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32
);
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [2:0]                  aw_prot;
    logic                        aw_valid;
    logic                        aw_ready;
    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_valid;
    logic                        w_ready;
    logic [1:0]                  b_resp;
    logic                        b_valid;
    logic                        b_ready;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [2:0]                  ar_prot;
    logic                        ar_valid;
    logic                        ar_ready;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_valid;
    logic                        r_ready;

    modport Initiator (
        output aw_addr, aw_prot, aw_valid, input aw_ready,
        output w_data, w_strb, w_valid, input w_ready,
        input b_resp, b_valid, output b_ready,
        output ar_addr, ar_prot, ar_valid, input ar_ready,
        input r_data, r_resp, r_valid, output r_ready
    );

    modport Target (
        input aw_addr, aw_prot, aw_valid, output aw_ready,
        input w_data, w_strb, w_valid, output w_ready,
        output b_resp, b_valid, input b_ready,
        input ar_addr, ar_prot, ar_valid, output ar_ready,
        output r_data, r_resp, r_valid, input r_ready
    );

endinterface

// File: rtl/dmi_axi_bridge.sv
// Turns DMI register accesses into single AXI-Lite transactions.
// One transaction in flight; every handshake output is a flop.
module dmi_axi_bridge
    import dm::*;
#(
    parameter int unsigned             AxiAddrWidth = 32,
    parameter logic [AxiAddrWidth-1:0] AddrBase     = '0
) (
    input  logic      clk,
    input  logic      rst,
    AXI_LITE.Initiator axilite,
    input  logic      dmi_rst_n_i,
    input  dmi_req_t  dmi_req_i,
    input  logic      dmi_req_valid_i,
    output logic      dmi_req_ready_o,
    output dmi_resp_t dmi_resp_o,
    output logic      dmi_resp_valid_o,
    input  logic      dmi_resp_ready_i
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRITE_RESP,
        READ,
        READ_DATA,
        RESP
    } state_e;

    state_e                  state_q;
    logic                    aw_valid_q;
    logic                    w_valid_q;
    logic                    ar_valid_q;
    logic                    b_ready_q;
    logic                    r_ready_q;
    logic                    drop_q;
    logic [AxiAddrWidth-1:0] addr_q;
    logic [31:0]             wdata_q;

    logic clear;
    logic aw_done;
    logic w_done;

    assign clear   = !dmi_rst_n_i;
    assign aw_done = !aw_valid_q || axilite.aw_ready;
    assign w_done  = !w_valid_q || axilite.w_ready;

    assign axilite.aw_addr  = addr_q;
    assign axilite.aw_prot  = 3'b000;
    assign axilite.aw_valid = aw_valid_q;
    assign axilite.w_data   = wdata_q;
    assign axilite.w_strb   = 4'hF;
    assign axilite.w_valid  = w_valid_q;
    assign axilite.b_ready  = b_ready_q;
    assign axilite.ar_addr  = addr_q;
    assign axilite.ar_prot  = 3'b000;
    assign axilite.ar_valid = ar_valid_q;
    assign axilite.r_ready  = r_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            aw_valid_q       <= 1'b0;
            w_valid_q        <= 1'b0;
            ar_valid_q       <= 1'b0;
            b_ready_q        <= 1'b0;
            r_ready_q        <= 1'b0;
            drop_q           <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            dmi_req_ready_o  <= 1'b0;
            dmi_resp_o       <= '0;
            dmi_resp_valid_o <= 1'b0;
        end else begin
            // A DMI clear mid-flight lets AXI finish but forgets the answer.
            if (clear && state_q != IDLE) begin
                drop_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    dmi_req_ready_o <= !clear;
                    if (!clear && dmi_req_ready_o && dmi_req_valid_i) begin
                        dmi_req_ready_o <= 1'b0;
                        addr_q  <= AddrBase
                                 + AxiAddrWidth'({dmi_req_i.addr, 2'b00});
                        wdata_q <= dmi_req_i.data;
                        case (dtm_op_e'(dmi_req_i.op))
                            DTM_READ: begin
                                ar_valid_q <= 1'b1;
                                state_q    <= READ;
                            end
                            DTM_WRITE: begin
                                aw_valid_q <= 1'b1;
                                w_valid_q  <= 1'b1;
                                state_q    <= WRITE;
                            end
                            default: begin
                                dmi_resp_o       <= '0;
                                dmi_resp_valid_o <= 1'b1;
                                state_q          <= RESP;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    if (axilite.aw_ready) aw_valid_q <= 1'b0;
                    if (axilite.w_ready)  w_valid_q  <= 1'b0;
                    if (aw_done && w_done) begin
                        b_ready_q <= 1'b1;
                        state_q   <= WRITE_RESP;
                    end
                end
                WRITE_RESP: begin
                    if (axilite.b_valid) begin
                        b_ready_q <= 1'b0;
                        if (drop_q || clear) begin
                            drop_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            dmi_resp_o.data  <= '0;
                            dmi_resp_o.resp  <= axi_to_dtm(axilite.b_resp);
                            dmi_resp_valid_o <= 1'b1;
                            state_q          <= RESP;
                        end
                    end
                end
                READ: begin
                    if (axilite.ar_ready) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state_q    <= READ_DATA;
                    end
                end
                READ_DATA: begin
                    if (axilite.r_valid) begin
                        r_ready_q <= 1'b0;
                        if (drop_q || clear) begin
                            drop_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            dmi_resp_o.data  <= axilite.r_data;
                            dmi_resp_o.resp  <= axi_to_dtm(axilite.r_resp);
                            dmi_resp_valid_o <= 1'b1;
                            state_q          <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (clear || dmi_resp_ready_i) begin
                        dmi_resp_valid_o <= 1'b0;
                        drop_q           <= 1'b0;
                        state_q          <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmi_axi_bridge.sv
// Directed scoreboard bench for dmi_axi_bridge with a small AXI-Lite target.
// Stimulus changes 1 time unit after posedge; the target and monitors act on negedge.
module tb_dmi_axi_bridge;
    import dm::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      dmi_rst_n;
    dmi_req_t  req;
    logic      req_valid;
    logic      req_ready;
    dmi_resp_t resp;
    logic      resp_valid;
    logic      resp_ready;

    AXI_LITE #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) axi ();

    dmi_axi_bridge #(
        .AxiAddrWidth(32),
        .AddrBase    (32'h0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .axilite         (axi),
        .dmi_rst_n_i     (dmi_rst_n),
        .dmi_req_i       (req),
        .dmi_req_valid_i (req_valid),
        .dmi_req_ready_o (req_ready),
        .dmi_resp_o      (resp),
        .dmi_resp_valid_o(resp_valid),
        .dmi_resp_ready_i(resp_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    dmi_resp_t   exp_resp[$];
    logic [31:0] exp_aw[$];
    logic [31:0] exp_ar[$];
    logic [35:0] exp_w[$];

    int          aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0;
    logic [1:0]  bresp_k = 2'd0, rresp_k = 2'd0;
    logic [31:0] rdata_k = 32'h0;

    int aw_wait = 0, w_wait = 0, ar_wait = 0, r_wait = 0;
    int aw_hs = 0, w_hs = 0, ar_hs = 0, b_done = 0, r_done = 0;
    bit b_fire = 0, r_fire = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(string name, logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h, required none", name, act);
    endtask

    function automatic logic [63:0] outs();
        return {23'b0, req_ready, resp_valid, resp,
                axi.aw_valid, axi.w_valid, axi.ar_valid,
                axi.b_ready, axi.r_ready};
    endfunction

    // AXI-Lite target with per-channel ready latency and scripted responses
    initial begin
        axi.aw_ready = 1'b0;
        axi.w_ready  = 1'b0;
        axi.ar_ready = 1'b0;
        axi.b_valid  = 1'b0;
        axi.b_resp   = 2'd0;
        axi.r_valid  = 1'b0;
        axi.r_data   = 32'h0;
        axi.r_resp   = 2'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                axi.aw_ready = 1'b0;
                axi.w_ready  = 1'b0;
                axi.ar_ready = 1'b0;
                axi.b_valid  = 1'b0;
                axi.r_valid  = 1'b0;
                aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 0;
                aw_hs = 0; w_hs = 0; ar_hs = 0; b_done = 0; r_done = 0;
                b_fire = 0; r_fire = 0;
            end else begin
                if (b_fire) begin
                    axi.b_valid = 1'b0;
                    b_done++;
                end
                if (r_fire) begin
                    axi.r_valid = 1'b0;
                    r_done++;
                end
                if (!axi.b_valid && aw_hs > b_done && w_hs > b_done) begin
                    axi.b_valid = 1'b1;
                    axi.b_resp  = bresp_k;
                end
                if (!axi.r_valid && ar_hs > r_done) begin
                    if (r_wait >= r_lat) begin
                        axi.r_valid = 1'b1;
                        axi.r_data  = rdata_k;
                        axi.r_resp  = rresp_k;
                        r_wait = 0;
                    end else begin
                        r_wait++;
                    end
                end
                if (axi.aw_valid) begin
                    aw_wait++;
                    axi.aw_ready = (aw_wait > aw_lat);
                end else begin
                    aw_wait = 0;
                    axi.aw_ready = 1'b0;
                end
                if (axi.w_valid) begin
                    w_wait++;
                    axi.w_ready = (w_wait > w_lat);
                end else begin
                    w_wait = 0;
                    axi.w_ready = 1'b0;
                end
                if (axi.ar_valid) begin
                    ar_wait++;
                    axi.ar_ready = (ar_wait > ar_lat);
                end else begin
                    ar_wait = 0;
                    axi.ar_ready = 1'b0;
                end
                if (axi.aw_valid && axi.aw_ready) begin
                    aw_hs++;
                    aw_wait = 0;
                    if (exp_aw.size() == 0)
                        unexpected("aw_beat", 64'(axi.aw_addr));
                    else
                        check("aw_addr", {axi.aw_prot, axi.aw_addr},
                              {3'b0, exp_aw.pop_front()});
                end
                if (axi.w_valid && axi.w_ready) begin
                    w_hs++;
                    w_wait = 0;
                    if (exp_w.size() == 0)
                        unexpected("w_beat", 64'(axi.w_data));
                    else
                        check("w_beat", {axi.w_strb, axi.w_data},
                              exp_w.pop_front());
                end
                if (axi.ar_valid && axi.ar_ready) begin
                    ar_hs++;
                    ar_wait = 0;
                    if (exp_ar.size() == 0)
                        unexpected("ar_beat", 64'(axi.ar_addr));
                    else
                        check("ar_addr", {axi.ar_prot, axi.ar_addr},
                              {3'b0, exp_ar.pop_front()});
                end
                b_fire = axi.b_valid && axi.b_ready;
                r_fire = axi.r_valid && axi.r_ready;
            end
        end
    end

    // DMI response monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && resp_valid && resp_ready) begin
                if (exp_resp.size() == 0) begin
                    unexpected("dmi_resp", 64'(resp));
                end else begin
                    check("dmi_resp", 64'(resp), 64'(exp_resp.pop_front()));
                    check("no_busy", 64'(resp.resp == DTM_BUSY), 64'd0);
                end
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(logic [16:0] a, logic [1:0] op, logic [31:0] d);
        int k = 0;
        req.addr  = a;
        req.op    = op;
        req.data  = d;
        req_valid = 1'b1;
        while (!req_ready && k < 100) begin
            tick();
            k++;
        end
        if (!req_ready) begin
            unexpected("req_accept_timeout", 64'(a));
            req_valid = 1'b0;
        end else begin
            tick();
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_resp.size() != 0 || resp_valid) && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) begin
            unexpected("drain_timeout", 64'(exp_resp.size()));
            exp_resp.delete();
        end
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        dmi_resp_t snap;
        bit        stable;
        bit        rdy_seen;
        int        a0, w0, r0, k;

        rst        = 1'b1;
        dmi_rst_n  = 1'b1;
        req        = '0;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick(3);
        check("reset_outputs", outs(), 64'd0);
        rst = 1'b0;
        tick(2);
        check("idle_req_ready", 64'(req_ready), 64'd1);

        // Write, OKAY
        exp_aw.push_back(32'h40);
        exp_w.push_back({4'hF, 32'hCAFE_F00D});
        exp_resp.push_back('{data: 32'h0, resp: DTM_SUCCESS});
        send(17'h00010, DTM_WRITE, 32'hCAFE_F00D);
        check("aw_w_valid_n1", {62'd0, axi.aw_valid, axi.w_valid}, 64'd3);
        drain();

        // Read, OKAY
        rdata_k = 32'h1234_5678;
        rresp_k = 2'd0;
        exp_ar.push_back(32'h0C);
        exp_resp.push_back('{data: 32'h1234_5678, resp: DTM_SUCCESS});
        send(17'h00003, DTM_READ, 32'h0);
        check("ar_valid_n1", 64'(axi.ar_valid), 64'd1);
        drain();

        // Read SLVERR at the top DMI address
        rdata_k = 32'hDEAD_BEEF;
        rresp_k = 2'd2;
        exp_ar.push_back(32'h0007_FFFC);
        exp_resp.push_back('{data: 32'hDEAD_BEEF, resp: DTM_ERR});
        send(17'h1FFFF, DTM_READ, 32'h0);
        drain();

        // Read EXOKAY at address 0
        rdata_k = 32'h0000_0001;
        rresp_k = 2'd1;
        exp_ar.push_back(32'h0);
        exp_resp.push_back('{data: 32'h0000_0001, resp: DTM_SUCCESS});
        send(17'h00000, DTM_READ, 32'h0);
        drain();

        // Write DECERR
        bresp_k = 2'd3;
        exp_aw.push_back(32'h4);
        exp_w.push_back({4'hF, 32'h0F0F_0F0F});
        exp_resp.push_back('{data: 32'h0, resp: DTM_ERR});
        send(17'h00001, DTM_WRITE, 32'h0F0F_0F0F);
        drain();
        bresp_k = 2'd0;

        // W accepted 5 cycles before AW
        aw_lat = 5;
        w_lat  = 0;
        a0 = aw_hs;
        w0 = w_hs;
        exp_aw.push_back(32'h8);
        exp_w.push_back({4'hF, 32'hA5A5_A5A5});
        exp_resp.push_back('{data: 32'h0, resp: DTM_SUCCESS});
        send(17'h00002, DTM_WRITE, 32'hA5A5_A5A5);
        drain();
        check("one_aw", 64'(aw_hs - a0), 64'd1);
        check("one_w", 64'(w_hs - w0), 64'd1);
        aw_lat = 0;

        // Response back-pressure for 10 cycles
        resp_ready = 1'b0;
        rdata_k = 32'h0BAD_F00D;
        rresp_k = 2'd0;
        exp_ar.push_back(32'h20);
        exp_resp.push_back('{data: 32'h0BAD_F00D, resp: DTM_SUCCESS});
        send(17'h00008, DTM_READ, 32'h0);
        k = 0;
        while (!resp_valid && k < 50) begin
            tick();
            k++;
        end
        check("resp_valid_seen", 64'(resp_valid), 64'd1);
        snap = resp;
        stable = 1'b1;
        rdy_seen = 1'b0;
        req.addr = 17'h0;
        req.op = DTM_NOP;
        req.data = 32'h0;
        req_valid = 1'b1;
        repeat (10) begin
            tick();
            if (resp !== snap || !resp_valid) stable = 1'b0;
            if (req_ready) rdy_seen = 1'b1;
        end
        req_valid = 1'b0;
        check("resp_stable", 64'(stable), 64'd1);
        check("req_ready_held_low", 64'(rdy_seen), 64'd0);
        resp_ready = 1'b1;
        drain();

        // DMI clear while AR waits
        ar_lat = 8;
        rdata_k = 32'h1111_1111;
        exp_ar.push_back(32'h14);
        r0 = r_done;
        send(17'h00005, DTM_READ, 32'h0);
        dmi_rst_n = 1'b0;
        tick();
        dmi_rst_n = 1'b1;
        check("ar_valid_held", {62'd0, axi.ar_valid, axi.ar_ready}, 64'd2);
        k = 0;
        while (r_done == r0 && k < 100) begin
            tick();
            k++;
        end
        check("r_consumed", 64'(r_done - r0), 64'd1);
        tick(3);
        check("dropped_no_resp", 64'(resp_valid), 64'd0);
        check("clear_back_idle", 64'(req_ready), 64'd1);
        ar_lat = 0;

        // rst in READ_DATA
        r_lat = 20;
        exp_ar.push_back(32'h1C);
        send(17'h00007, DTM_READ, 32'h0);
        k = 0;
        while (!axi.r_ready && k < 50) begin
            tick();
            k++;
        end
        check("in_read_data", 64'(axi.r_ready), 64'd1);
        rst = 1'b1;
        tick();
        check("rst_outputs", outs(), 64'd0);
        rst = 1'b0;
        r_lat = 0;
        tick(2);

        // NOP and op 3: no AXI traffic, zero data, success
        a0 = aw_hs + w_hs + ar_hs;
        exp_resp.push_back('{data: 32'h0, resp: DTM_SUCCESS});
        send(17'h00003, DTM_NOP, 32'h0000_0055);
        drain();
        exp_resp.push_back('{data: 32'h0, resp: DTM_SUCCESS});
        send(17'h00004, 2'd3, 32'hFFFF_FFFF);
        drain();
        check("nop_no_axi", 64'(aw_hs + w_hs + ar_hs - a0), 64'd0);

        check("axi_queues_empty",
              64'(exp_aw.size() + exp_ar.size() + exp_w.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
